// File: rtl/fft_stage_sequencer_if.sv
// Handshake and address bundle between the FFT sequencer and
// the address_control / butterfly datapath.
interface fft_stage_sequencer_if #(
    parameter int NUMSTAGES = 5
);
    logic                 start;
    logic                 stall;
    logic [NUMSTAGES-3:0] counter_r;
    logic [2:0]           stage_num_r;
    logic                 rd_en;
    logic [NUMSTAGES-3:0] wr_counter;
    logic [2:0]           wr_stage;
    logic                 wr_en;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, stall,
        output counter_r, stage_num_r, rd_en,
        output wr_counter, wr_stage, wr_en,
        output busy, done
    );

    modport slave (
        output start, stall,
        input  counter_r, stage_num_r, rd_en,
        input  wr_counter, wr_stage, wr_en,
        input  busy, done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Read/write butterfly sequencer for the in-place radix-2 FFT:
// issues per-stage reads, mirrors them to writes, drains between stages.
module fft_stage_sequencer #(
    parameter int NUMSTAGES    = 5,
    parameter int BFLY_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_stage_sequencer_if.master bus
);
    localparam int CW = NUMSTAGES - 2;
    localparam int L  = BFLY_LATENCY;

    localparam logic [CW-1:0] LASTC = {CW{1'b1}};
    localparam logic [2:0]    LASTS = 3'(NUMSTAGES - 1);
    localparam logic [L-1:0]  TAILM = L'(1) << (L - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t          r_state;
    logic            r_rd;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_stg;
    logic [L-1:0]    r_pv;
    logic [CW-1:0]   r_pc [L];
    logic [2:0]      r_ps [L];

    // Safe to start the next stage once only the tail entry is still valid:
    // it retires on this edge, so the pipeline is empty afterwards.
    logic w_drained;
    assign w_drained = ~|(r_pv & ~TAILM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_stg   <= '0;
            r_pv    <= '0;
            for (int i = 0; i < L; i++) begin
                r_pc[i] <= '0;
                r_ps[i] <= '0;
            end
        end else if (!bus.stall) begin
            r_pv[0] <= r_rd;
            r_pc[0] <= r_rd ? r_cnt : '0;
            r_ps[0] <= r_rd ? r_stg : '0;
            for (int i = 1; i < L; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pc[i] <= r_pc[i-1];
                r_ps[i] <= r_ps[i-1];
            end

            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_READ;
                        r_rd    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_stg   <= '0;
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LASTC) begin
                        r_state <= S_DRAIN;
                        r_rd    <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        if (r_stg < LASTS) begin
                            r_stg   <= r_stg + 3'd1;
                            r_state <= S_READ;
                            r_rd    <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_stg   <= '0;
                end
            endcase
        end
    end

    assign bus.rd_en       = r_rd & ~bus.stall;
    assign bus.counter_r   = r_cnt;
    assign bus.stage_num_r = r_stg;
    assign bus.wr_en       = r_pv[L-1] & ~bus.stall;
    assign bus.wr_counter  = r_pc[L-1];
    assign bus.wr_stage    = r_ps[L-1];
    assign bus.busy        = r_busy;
    assign bus.done        = r_done & ~bus.stall;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: two sequencer configurations driven in lockstep,
// each checked cycle by cycle against a run-index reference model.
module tb_fft_stage_sequencer;
    typedef struct {
        bit rd;
        bit chk_rd;
        int cnt;
        int stg;
        bit wr;
        int wcnt;
        int wstg;
        bit busy;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    bit ra = 0, rb = 0;
    int ka = 0, kb = 0;
    int last_cyc = 0;

    int a_done_n = 0, b_done_n = 0;
    int a_done_cyc = -1, b_done_cyc = -1;
    int a_busy_rise = -1;
    bit a_busy_prev = 0;

    fft_stage_sequencer_if #(.NUMSTAGES(5)) ifa ();
    fft_stage_sequencer_if #(.NUMSTAGES(4)) ifb ();

    fft_stage_sequencer #(.NUMSTAGES(5), .BFLY_LATENCY(3)) u_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa.master)
    );

    fft_stage_sequencer #(.NUMSTAGES(4), .BFLY_LATENCY(1)) u_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: run index k counts unstalled cycles since start
    // (k=1 is the first read cycle); everything follows from k.
    function automatic exp_t model_out(bit run, int k, int ns, int l,
                                       bit st, bit rst);
        exp_t e = '{default: 0};
        int nbf, p, t, s, off;
        if (rst) begin
            e.chk_rd = 1;
            return e;
        end
        if (!run) return e;
        nbf = 1 << (ns - 2);
        p   = nbf + l;
        t   = ns * p;
        if (k == t + 1) begin
            e.done = !st;
            return e;
        end
        s      = (k - 1) / p;
        off    = (k - 1) % p;
        e.busy = 1;
        if (off < nbf) begin
            e.chk_rd = 1;
            e.rd     = !st;
            e.cnt    = off;
            e.stg    = s;
        end
        if (off >= l && off < l + nbf) begin
            e.wr   = !st;
            e.wcnt = off - l;
            e.wstg = s;
        end
        return e;
    endfunction

    function automatic void model_step(inout bit run, inout int k,
                                       input int ns, input int l,
                                       input bit st, input bit rst,
                                       input bit go);
        int t = ns * ((1 << (ns - 2)) + l);
        if (rst) begin
            run = 0;
            k   = 0;
        end else if (!st) begin
            if (!run) begin
                if (go) begin
                    run = 1;
                    k   = 1;
                end
            end else if (k == t + 1) begin
                run = 0;
                k   = 0;
            end else begin
                k++;
            end
        end
    endfunction

    task automatic step(bit s_start, bit s_stall, bit s_rst);
        @(posedge clk);
        #1;
        rst_n     = !s_rst;
        ifa.start = s_start;
        ifa.stall = s_stall;
        ifb.start = s_start;
        ifb.stall = s_stall;
        last_cyc  = cyc;
        qa.push_back(model_out(ra, ka, 5, 3, s_stall, s_rst));
        qb.push_back(model_out(rb, kb, 4, 1, s_stall, s_rst));
        model_step(ra, ka, 5, 3, s_stall, s_rst, s_start);
        model_step(rb, kb, 4, 1, s_stall, s_rst, s_start);
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp(string nm, exp_t e, exp_t a);
        bit bad;
        checks++;
        bad = (a.rd != e.rd) || (a.wr != e.wr) || (a.busy != e.busy) ||
              (a.done != e.done) || (a.wcnt != e.wcnt) ||
              (a.wstg != e.wstg) ||
              (e.chk_rd && (a.cnt != e.cnt || a.stg != e.stg));
        if (bad) begin
            errors++;
            $display("FAIL %s cyc=%0d act rd=%0d c=%0d s=%0d wr=%0d wc=%0d ws=%0d b=%0d d=%0d exp rd=%0d c=%0d s=%0d wr=%0d wc=%0d ws=%0d b=%0d d=%0d",
                     nm, cyc, a.rd, a.cnt, a.stg, a.wr, a.wcnt, a.wstg,
                     a.busy, a.done, e.rd, e.cnt, e.stg, e.wr, e.wcnt,
                     e.wstg, e.busy, e.done);
        end
    endtask

    always @(negedge clk) begin
        exp_t a;
        a.chk_rd = 0;
        if (qa.size() > 0) begin
            a.rd   = ifa.rd_en;
            a.cnt  = int'(ifa.counter_r);
            a.stg  = int'(ifa.stage_num_r);
            a.wr   = ifa.wr_en;
            a.wcnt = int'(ifa.wr_counter);
            a.wstg = int'(ifa.wr_stage);
            a.busy = ifa.busy;
            a.done = ifa.done;
            cmp("seqA", qa.pop_front(), a);
        end
        if (qb.size() > 0) begin
            a.rd   = ifb.rd_en;
            a.cnt  = int'(ifb.counter_r);
            a.stg  = int'(ifb.stage_num_r);
            a.wr   = ifb.wr_en;
            a.wcnt = int'(ifb.wr_counter);
            a.wstg = int'(ifb.wr_stage);
            a.busy = ifb.busy;
            a.done = ifb.done;
            cmp("seqB", qb.pop_front(), a);
        end
        if (ifa.done) begin
            a_done_n++;
            a_done_cyc = cyc;
        end
        if (ifb.done) begin
            b_done_n++;
            b_done_cyc = cyc;
        end
        if (ifa.busy && !a_busy_prev) a_busy_rise = cyc;
        a_busy_prev = ifa.busy;
    end

    initial begin
        int c, na, nb;
        ifa.start = 0;
        ifa.stall = 0;
        ifb.start = 0;
        ifb.stall = 0;

        repeat (3) step(0, 0, 1);
        repeat (2) step(0, 0, 0);

        // plain run
        na = a_done_n;
        nb = b_done_n;
        step(1, 0, 0);
        c = last_cyc;
        repeat (65) step(0, 0, 0);
        chk("run_doneA", a_done_cyc, c + 56);
        chk("run_doneB", b_done_cyc, c + 21);
        chk("run_firstrd", a_busy_rise, c + 1);
        chk("run_npulseA", a_done_n - na, 1);
        chk("run_npulseB", b_done_n - nb, 1);

        // stall during stage 0
        step(1, 0, 0);
        c = last_cyc;
        for (int i = 1; i <= 70; i++) step(0, i >= 5 && i <= 7, 0);
        chk("stall_doneA", a_done_cyc, c + 59);
        chk("stall_doneB", b_done_cyc, c + 24);

        // reset mid-transform
        na = a_done_n;
        nb = b_done_n;
        step(1, 0, 0);
        for (int i = 1; i <= 70; i++) step(0, 0, i == 30 || i == 31);
        chk("rst_nodoneA", a_done_n - na, 0);
        chk("rst_doneB", b_done_n - nb, 1);
        step(1, 0, 0);
        c = last_cyc;
        repeat (60) step(0, 0, 0);
        chk("rst_rerunA", a_done_cyc, c + 56);
        chk("rst_rerun_rd", a_busy_rise, c + 1);

        // start held high across two runs
        na = a_done_n;
        step(1, 0, 0);
        c = last_cyc;
        for (int i = 1; i <= 120; i++) step(i <= 60, 0, 0);
        chk("held_rd2", a_busy_rise, c + 58);
        chk("held_done2", a_done_cyc, c + 113);
        chk("held_npulse", a_done_n - na, 2);

        // extra start while busy
        na = a_done_n;
        step(1, 0, 0);
        c = last_cyc;
        for (int i = 1; i <= 80; i++) step(i == 20, 0, 0);
        chk("busy_start_n", a_done_n - na, 1);
        chk("busy_start_done", a_done_cyc, c + 56);

        for (int i = 0; i < 900; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 149) == 0);
        repeat (80) step(0, 0, 0);

        @(negedge clk);
        #1;
        chk("sb_drainA", qa.size(), 0);
        chk("sb_drainB", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control-side driver for `address_control` in the 32-point radix-2 FFT datapath.
- Generates the butterfly counter and stage number that `address_control` decodes into bank read/write addresses.
- Delays a matched write-side counter/stage through a pipeline equal to the butterfly latency.
- Holds off each new stage until all writes of the previous stage have landed (in-place memory hazard).
- Sits between the top-level FFT start/done handshake and `address_control`/butterfly.

Parameters:
- NUMSTAGES, 5, log2 of FFT size. Counter width is NUMSTAGES-2; legal range 3..8.
- BFLY_LATENCY, 3, cycles from read issue to matching write. Legal range 1..8.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level, sampled only in IDLE; begins one transform.
- stall  in  1  freezes all state; masks rd_en/wr_en while high.
- counter_r  out  NUMSTAGES-2  read-side butterfly index, to address_control.
- stage_num_r  out  3  read-side stage index, to address_control.
- rd_en  out  1  counter_r/stage_num_r valid for a bank read this cycle.
- wr_counter  out  NUMSTAGES-2  write-side butterfly index.
- wr_stage  out  3  write-side stage index.
- wr_en  out  1  wr_counter/wr_stage valid for a bank write this cycle.
- busy  out  1  high from first read cycle through last write cycle.
- done  out  1  one-cycle pulse after the last write of the final stage.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - Pipeline valids cleared.
  - All outputs 0 immediately, including wr_en mid-transform.
  - No done pulse for an aborted run.
- Constants: N_BF = 2^(NUMSTAGES-2) butterflies per stage; default 8.
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE: start=1 at edge -> READ, counter_r=0, stage_num_r=0.
  - READ: rd_en=1; counter_r increments each cycle.
    - At counter_r=N_BF-1: counter_r wraps to 0 -> DRAIN.
  - DRAIN: rd_en=0; wait until the write pipeline holds no valid entry after this cycle.
    - If stage_num_r<NUMSTAGES-1: stage_num_r+1 -> READ.
    - Else -> FIN.
  - FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
  - start is ignored outside IDLE.
  - start held high continuously: the next run begins on the edge after FIN.
- Write pipeline:
  - BFLY_LATENCY-deep shift of {rd_en, counter_r, stage_num_r}.
  - wr_en/wr_counter/wr_stage equal the read-side values exactly BFLY_LATENCY non-stalled cycles earlier.
  - wr_counter/wr_stage are 0 when wr_en=0.
- Stage timing (no stall):
  - Period = N_BF + BFLY_LATENCY cycles.
  - First read of stage s+1 falls in the cycle after the last write of stage s.
  - Default period 11 cycles.
- Run timing (no stall), start sampled at edge of cycle 0:
  - Reads of stage s: cycles 1+11s .. 8+11s.
  - Writes of stage s: cycles 4+11s .. 11+11s.
  - busy: cycles 1..55.
  - done: cycle 56.
  - Total = NUMSTAGES*(N_BF+BFLY_LATENCY)+1 cycles to done.
- Stall:
  - While stall=1, FSM, counter, stage and pipeline all hold.
  - rd_en=0 and wr_en=0 (combinational mask); counter/stage outputs hold their values; busy holds.
  - On release, the sequence resumes where it left off; no read or write is dropped or duplicated.
  - stall in IDLE blocks start acceptance.
  - stall in FIN delays done; done is still exactly one unstalled cycle.
- Arithmetic: counter wraps modulo N_BF. stage_num_r never exceeds NUMSTAGES-1.

Test Plan:
- Reset release, start=1 at cycle 0, defaults:
  - rd_en cycles 1-8 with counter 0..7, stage 0.
  - wr_en cycles 4-11 with wr_counter 0..7.
  - Stage 1 first read at cycle 12.
  - done single pulse at cycle 56, busy low at 56.
- Full run, log all (rd stage, counter) and (wr stage, counter) pairs:
  - Each of 40 pairs appears exactly once on each side, in order.
  - No read of stage s+1 before the last write of stage s.
- stall=1 for cycles 5-7 during stage 0:
  - rd_en/wr_en low in 5-7.
  - Read of counter 4 occurs at cycle 8.
  - done slips to cycle 59.
- rst_n=0 at cycle 30 (stage 2):
  - All outputs 0 asynchronously.
  - No done pulse.
  - After release with start=1, a clean run from stage 0, counter 0.
- start held high: second run's first read occurs at cycle 58; a start pulse at cycle 20 (busy) has no effect.
- BFLY_LATENCY=1, NUMSTAGES=4:
  - N_BF=4, period 5.
  - done at cycle 21.
  - wr_counter trails counter_r by 1 cycle.
